lbus_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one local-bus master port (the port that drives axi2lbus_bridge) between NumReq requester FSMs, e.g. a UART echo engine plus a debug/config engine.
- Captures single-cycle requests into per-requester one-deep slots.
- Issues one transaction at a time downstream, tagged with the requester index on bus_id.
- Routes the read data and ready pulse back to the owning requester.

---
 rtl/lbus_pkg.sv | 23 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/lbus_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_lbus_rr_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lbus_pkg
//  Description : Shared widths, FSM state type and timeout fill data for the
//                local-bus round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package lbus_pkg;

   localparam int LBUS_ADDR_W = 4;
   localparam int LBUS_STRB_W = 4;
   localparam int LBUS_DATA_W = 32;

   localparam logic [31:0] LBUS_TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker: first pending index at or
//                after ptr, wrapping modulo NumReq.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NumReq = 2,
   parameter int IdW    = 1
) (
   input  logic [NumReq-1:0] pending,
   input  logic [IdW-1:0]    ptr,
   output logic              valid,
   output logic [IdW-1:0]    idx
);

   logic [NumReq-1:0] w_rot;
   logic [IdW:0]      w_sum;

   // Rotate so bit k means "requester ptr+k"; scanning downwards lets the
   // lowest offset win.
   always_comb begin
      w_rot = NumReq'({pending, pending} >> ptr);
      valid = 1'b0;
      idx   = '0;
      w_sum = '0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_sum = {1'b0, ptr} + (IdW + 1)'(k);
            if (w_sum >= (IdW + 1)'(NumReq)) begin
               w_sum = w_sum - (IdW + 1)'(NumReq);
            end
            valid = 1'b1;
            idx   = w_sum[IdW-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lbus_rr_arbiter
//  Description : Round-robin arbiter sharing one local-bus master port between
//                NumReq requesters. Optional WAIT timeout: LBUS_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lbus_rr_arbiter
   import lbus_pkg::*;
#(
   parameter int NumReq = 2,
   parameter int AddrW  = LBUS_ADDR_W,
   parameter int StrbW  = LBUS_STRB_W,
   parameter int DataW  = LBUS_DATA_W,
   parameter int IdW    = (NumReq > 1) ? $clog2(NumReq) : 1
`ifdef LBUS_ARB_TIMEOUT_EN
   ,
   parameter int TimeoutCyc = 1024
`endif
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NumReq-1:0]       m_req,
   input  logic [NumReq*AddrW-1:0] m_addr,
   input  logic [NumReq*StrbW-1:0] m_strb,
   input  logic [NumReq*DataW-1:0] m_wdata,
   output logic [NumReq-1:0]       m_busyo,
   output logic [NumReq-1:0]       m_readyo,
   output logic [DataW-1:0]        m_rdatao,
   output logic [AddrW-1:0]        bus_addro,
   output logic [IdW-1:0]          bus_ido,
   output logic                    bus_reqo,
   output logic [StrbW-1:0]        bus_strbo,
   output logic [DataW-1:0]        bus_wdatao,
   input  logic                    bus_busy,
   input  logic [IdW-1:0]          bus_id,
   input  logic [DataW-1:0]        bus_rdata,
   input  logic                    bus_ready
`ifdef LBUS_ARB_TIMEOUT_EN
   ,
   output logic                    timeout_o
`endif
);

   arb_state_t        r_state;
   logic [NumReq-1:0] r_pend;
   logic [NumReq-1:0] r_busy;
   logic [NumReq-1:0] r_readyo;
   logic [IdW-1:0]    r_ptr;
   logic [IdW-1:0]    r_grant;
   logic              r_id_err;
   logic [AddrW-1:0]  r_slot_addr  [NumReq];
   logic [StrbW-1:0]  r_slot_strb  [NumReq];
   logic [DataW-1:0]  r_slot_wdata [NumReq];
`ifdef LBUS_ARB_TIMEOUT_EN
   logic [15:0]       r_tcnt;
`endif

   logic [NumReq-1:0] w_cap;
   logic [NumReq-1:0] w_clr;
   logic              w_valid;
   logic [IdW-1:0]    w_idx;
   logic [IdW-1:0]    w_next_ptr;

   assign w_cap      = m_req & ~r_busy;
   assign w_clr      = (r_state == IDLE && w_valid) ? (NumReq'(1) << w_idx) : '0;
   assign w_next_ptr = (w_idx == IdW'(NumReq - 1)) ? '0 : w_idx + IdW'(1);
   assign m_busyo    = r_busy;
   assign m_readyo   = r_readyo;

   rr_pick #(
      .NumReq (NumReq),
      .IdW    (IdW)
   ) u_rr_pick (
      .pending (r_pend),
      .ptr     (r_ptr),
      .valid   (w_valid),
      .idx     (w_idx)
   );

   // Slot payload is only meaningful while pending, so it carries no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NumReq; i++) begin
         if (w_cap[i]) begin
            r_slot_addr[i]  <= m_addr[i*AddrW +: AddrW];
            r_slot_strb[i]  <= m_strb[i*StrbW +: StrbW];
            r_slot_wdata[i] <= m_wdata[i*DataW +: DataW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_pend     <= '0;
         r_busy     <= '0;
         r_readyo   <= '0;
         r_ptr      <= '0;
         r_grant    <= '0;
         r_id_err   <= 1'b0;
         m_rdatao   <= '0;
         bus_reqo   <= 1'b0;
         bus_addro  <= '0;
         bus_ido    <= '0;
         bus_strbo  <= '0;
         bus_wdatao <= '0;
`ifdef LBUS_ARB_TIMEOUT_EN
         r_tcnt     <= '0;
         timeout_o  <= 1'b0;
`endif
      end else begin
         r_readyo <= '0;
         bus_reqo <= 1'b0;
`ifdef LBUS_ARB_TIMEOUT_EN
         timeout_o <= 1'b0;
`endif
         // Busy drops the cycle after the completion pulse.
         r_busy <= (r_busy | w_cap) & ~r_readyo;
         r_pend <= (r_pend | w_cap) & ~w_clr;

         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  bus_reqo   <= 1'b1;
                  bus_addro  <= r_slot_addr[w_idx];
                  bus_strbo  <= r_slot_strb[w_idx];
                  bus_wdatao <= r_slot_wdata[w_idx];
                  bus_ido    <= w_idx;
                  r_grant    <= w_idx;
                  r_ptr      <= w_next_ptr;
                  r_state    <= WAIT;
`ifdef LBUS_ARB_TIMEOUT_EN
                  r_tcnt     <= '0;
`endif
               end
            end
            WAIT: begin
               if (bus_ready) begin
                  r_readyo <= NumReq'(1) << r_grant;
                  m_rdatao <= bus_rdata;
                  if (bus_id != r_grant) begin
                     r_id_err <= 1'b1;
                  end
                  r_state <= DRAIN;
               end
`ifdef LBUS_ARB_TIMEOUT_EN
               else if (r_tcnt == 16'(TimeoutCyc - 1)) begin
                  r_readyo  <= NumReq'(1) << r_grant;
                  m_rdatao  <= DataW'(LBUS_TIMEOUT_DATA);
                  timeout_o <= 1'b1;
                  r_state   <= DRAIN;
               end else begin
                  r_tcnt <= r_tcnt + 16'd1;
               end
`endif
            end
            DRAIN: begin
               if (!bus_busy) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_bus_id_match: assert (!r_id_err);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lbus_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lbus_rr_arbiter
//  Description : Self-checking bench for lbus_rr_arbiter with a bridge
//                responder and a transaction-level round-robin model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lbus_rr_arbiter;
   import lbus_pkg::*;

   localparam int NREQ = 2;
   localparam int AW   = 4;
   localparam int SW   = 4;
   localparam int DW   = 32;
   localparam int IW   = 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      m_req;
   logic [NREQ*AW-1:0]   m_addr;
   logic [NREQ*SW-1:0]   m_strb;
   logic [NREQ*DW-1:0]   m_wdata;
   logic [NREQ-1:0]      m_busyo;
   logic [NREQ-1:0]      m_readyo;
   logic [DW-1:0]        m_rdatao;
   logic [AW-1:0]        bus_addro;
   logic [IW-1:0]        bus_ido;
   logic                 bus_reqo;
   logic [SW-1:0]        bus_strbo;
   logic [DW-1:0]        bus_wdatao;
   logic                 bus_busy;
   logic [IW-1:0]        bus_id;
   logic [DW-1:0]        bus_rdata;
   logic                 bus_ready;
`ifdef LBUS_ARB_TIMEOUT_EN
   logic                 timeout_o;
`endif

   int checks   = 0;
   int failures = 0;
   int rr_ptr   = 0;
   int exp_q[$];

   logic [NREQ-1:0]    mask;
   logic [NREQ*AW-1:0] ap;
   logic [NREQ*SW-1:0] sp;
   logic [NREQ*DW-1:0] wp;

   lbus_rr_arbiter #(
      .NumReq (NREQ)
`ifdef LBUS_ARB_TIMEOUT_EN
      , .TimeoutCyc (16)
`endif
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .m_req      (m_req),
      .m_addr     (m_addr),
      .m_strb     (m_strb),
      .m_wdata    (m_wdata),
      .m_busyo    (m_busyo),
      .m_readyo   (m_readyo),
      .m_rdatao   (m_rdatao),
      .bus_addro  (bus_addro),
      .bus_ido    (bus_ido),
      .bus_reqo   (bus_reqo),
      .bus_strbo  (bus_strbo),
      .bus_wdatao (bus_wdatao),
      .bus_busy   (bus_busy),
      .bus_id     (bus_id),
      .bus_rdata  (bus_rdata),
      .bus_ready  (bus_ready)
`ifdef LBUS_ARB_TIMEOUT_EN
      , .timeout_o (timeout_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  m_busyo,    0);
      chk({tag, "_ready"}, m_readyo,   0);
      chk({tag, "_rdata"}, m_rdatao,   0);
      chk({tag, "_req"},   bus_reqo,   0);
      chk({tag, "_addr"},  bus_addro,  0);
      chk({tag, "_id"},    bus_ido,    0);
      chk({tag, "_strb"},  bus_strbo,  0);
      chk({tag, "_wdata"}, bus_wdatao, 0);
   endtask

   // Requests captured together are served in rotation starting at the
   // pointer; the pointer then sits just past the last one served.
   task automatic plan(input logic [NREQ-1:0] m);
      int last = -1;
      exp_q.delete();
      for (int k = 0; k < NREQ; k++) begin
         int i = (rr_ptr + k) % NREQ;
         if (m[i]) begin
            exp_q.push_back(i);
            last = i;
         end
      end
      if (last >= 0) rr_ptr = (last + 1) % NREQ;
   endtask

   // Bridge responder for one downstream transaction; junk requests from
   // still-busy requesters are fired while it is in flight.
   task automatic serve(input int id, input logic [AW-1:0] ea, input logic [SW-1:0] es,
                        input logic [DW-1:0] ew, input int exp_wait, input int lat,
                        input int tail, input logic [NREQ-1:0] junk, input logic [DW-1:0] rd);
      int n = 0;
      while (bus_reqo !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("req_wait", n, exp_wait);
      if (bus_reqo !== 1'b1) return;
      chk("bus_addr",  bus_addro,  ea);
      chk("bus_id",    bus_ido,    id);
      chk("bus_strb",  bus_strbo,  es);
      chk("bus_wdata", bus_wdatao, ew);
      bus_busy = 1'b1;
      for (int c = 0; c < lat; c++) begin
         if (c == 0) begin
            m_req  = junk;
            m_addr = (NREQ*AW)'($urandom);
         end
         tick();
         m_req = '0;
         chk("req_pulse",   bus_reqo, 0);
         chk("early_ready", m_readyo, 0);
      end
      bus_ready = 1'b1;
      bus_id    = IW'(id);
      bus_rdata = rd;
      tick();
      bus_ready = 1'b0;
      chk("readyo", m_readyo, 64'(1) << id);
      chk("rdata",  m_rdatao, rd);
      for (int t = 0; t < tail; t++) begin
         tick();
         chk("drain_hold", bus_reqo, 0);
      end
      bus_busy = 1'b0;
   endtask

   task automatic run_round(input logic [NREQ-1:0] m, input logic [NREQ*AW-1:0] a,
                            input logic [NREQ*SW-1:0] s, input logic [NREQ*DW-1:0] w,
                            input int lat, input int tail, input logic [DW-1:0] rd);
      int id;
      int first = 1;
      logic [NREQ-1:0] outstanding = m;
      m_req   = m;
      m_addr  = a;
      m_strb  = s;
      m_wdata = w;
      tick();
      m_req = '0;
      chk("busy_cap", m_busyo, m);
      plan(m);
      while (exp_q.size() > 0) begin
         id = exp_q.pop_front();
         serve(id, a[id*AW +: AW], s[id*SW +: SW], w[id*DW +: DW], first ? 1 : 2,
               (lat > 0) ? lat : int'($urandom_range(1, 4)),
               (tail >= 0) ? tail : int'($urandom_range(0, 3)),
               outstanding, (rd != 0) ? rd : DW'($urandom));
         outstanding[id] = 1'b0;
         first = 0;
      end
      tick();
      chk("busy_clear", m_busyo, 0);
      tick();
      chk("no_extra_req", bus_reqo, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      chk_all_zero("reset");
      reset  = 1'b0;
      rr_ptr = 0;
   endtask

   initial begin
      reset = 1'b1;
      m_req = '0; m_addr = '0; m_strb = '0; m_wdata = '0;
      bus_busy = 1'b0; bus_id = '0; bus_rdata = '0; bus_ready = 1'b0;
      repeat (3) tick();
      chk_all_zero("por");
      reset = 1'b0;
      rr_ptr = 0;

      // Single read from requester 0.
      run_round(2'b01, {4'h0, 4'h8}, '0, '0, 1, 0, 32'h1);

      // Contention, twice in a row, from a freshly reset pointer.
      do_reset();
      run_round(2'b11, {4'h4, 4'h0}, {4'b0001, 4'b0000}, {32'h41, 32'h0}, 0, -1, 0);
      run_round(2'b11, {4'h4, 4'h0}, {4'b0001, 4'b0000}, {32'h41, 32'h0}, 0, -1, 0);

      // Re-request by the in-flight requester must be dropped.
      run_round(2'b01, {4'h0, 4'hC}, '0, '0, 3, 0, 0);

      // Long bus_busy tail holds off the second grant.
      run_round(2'b11, {4'h2, 4'h3}, {4'b1111, 4'b0000}, {32'hA5A5_0001, 32'h0}, 2, 5, 0);

      for (int r = 0; r < 25; r++) begin
         mask = NREQ'($urandom_range(1, 3));
         ap   = (NREQ*AW)'($urandom);
         sp   = (NREQ*SW)'($urandom);
         wp   = {$urandom, $urandom};
         run_round(mask, ap, sp, wp, 0, -1, 0);
      end

      // Reset two cycles after the downstream request aborts the transaction.
      m_req = 2'b01; m_addr = {4'h0, 4'h5};
      tick();
      m_req = '0;
      tick();
      chk("abort_req", bus_reqo, 1);
      bus_busy = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk_all_zero("abort");
      bus_busy = 1'b0;
      tick();
      chk("abort_noready", m_readyo, 0);
      reset  = 1'b0;
      rr_ptr = 0;
      run_round(2'b10, {4'h9, 4'h0}, {4'b0010, 4'b0000}, {32'h1234_5678, 32'h0}, 2, 0, 0);

`ifdef LBUS_ARB_TIMEOUT_EN
      m_req = 2'b01; m_addr = {4'h0, 4'h7};
      tick();
      m_req = '0;
      tick();
      chk("to_req", bus_reqo, 1);
      bus_busy = 1'b1;
      for (int c = 1; c < 16; c++) begin
         tick();
         chk("to_early_ready", m_readyo, 0);
         chk("to_early_flag", timeout_o, 0);
      end
      tick();
      chk("to_ready", m_readyo, 2'b01);
      chk("to_rdata", m_rdatao, 32'hDEAD_BEEF);
      chk("to_flag",  timeout_o, 1);
      bus_ready = 1'b1; bus_id = '0; bus_rdata = 32'h55;
      tick();
      bus_ready = 1'b0;
      bus_busy  = 1'b0;
      chk("to_late_drop", m_readyo, 0);
      chk("to_flag_pulse", timeout_o, 0);
      repeat (2) tick();
      chk("to_busy_clear", m_busyo, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
